imem_loader: RTL and testbench

Program loader for the CPU's 16-bit instruction memory: the writing end of the fetch interface. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words (high byte first). It writes the words to consecutive instruction-memory addresses starting at 0. It runs before the CPU is released and reports completion, word count and a running checksum.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writes a big-endian byte stream into instruction memory.
// Two consecutive bytes form one 16-bit word, high byte first. Words go to
// addresses 0 .. DEPTH-1. The block reports completion, the number of words
// written and a 16-bit running checksum of those words.
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1, and on no other edge. in_ready depends only on the current
// state (HI or LO). It never depends on in_valid. The producer may hold
// in_valid low for any number of cycles, and the loader waits without limit.

module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Last address of a load. The loader stops here, so mem_addr never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [15:0]       sum_q, sum_d;
  logic              xfer;

  // Output decode. All outputs come from flops or from the state alone.
  always_comb begin
    in_ready   = (state_q == S_HI) || (state_q == S_LO);
    mem_we     = (state_q == S_WRITE);
    busy       = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    word_count = count_q;
    checksum   = sum_q;
  end

  // Next-state and datapath update. abort overrides every state transition
  // and freezes the counters, including during the WRITE cycle.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    sum_d   = sum_q;
    xfer    = in_valid && ((state_q == S_HI) || (state_q == S_LO));

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_HI;
            addr_d  = '0;
            count_d = '0;
            sum_d   = '0;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_d    = in_data;
            state_d = S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            wdata_d = {hi_q, in_data};
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          count_d = count_q + ONE;
          sum_d   = sum_q + wdata_q;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ONE;
            state_d = S_HI;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a write scoreboard.
// Two instances are used. dut4 has DEPTH=4 and dut1 has DEPTH=1.

module tb_imem_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (DEPTH=4) ----------------
  logic        start, abort, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done;
  logic [15:0] mem_addr, mem_wdata, word_count, checksum;

  imem_loader #(.DEPTH(4), .ADDR_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .word_count(word_count), .checksum(checksum)
  );

  // ---------------- DUT (DEPTH=1) ----------------
  logic        d1_start, d1_abort, d1_valid;
  logic [7:0]  d1_data;
  logic        d1_ready, d1_we, d1_busy, d1_done;
  logic [15:0] d1_addr, d1_wdata, d1_count, d1_sum;

  imem_loader #(.DEPTH(1), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(d1_start), .abort(d1_abort),
    .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
    .mem_we(d1_we), .mem_addr(d1_addr), .mem_wdata(d1_wdata),
    .busy(d1_busy), .done(d1_done), .word_count(d1_count), .checksum(d1_sum)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];     // {addr, data} of each expected write
  int          we_cyc[$];    // cycle of each observed write on dut4
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_sum;
  logic [15:0] model_cnt;
  int          start_cyc;
  logic [7:0]  stream [0:7];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] outs4();
    return {4'b0, in_ready, mem_we, busy, done, mem_addr, mem_wdata, word_count, checksum};
  endfunction

  function automatic logic [71:0] outs1();
    return {4'b0, d1_ready, d1_we, d1_busy, d1_done, d1_addr, d1_wdata, d1_count, d1_sum};
  endfunction

  task automatic push_word(input logic [15:0] addr, input logic [15:0] data);
    exp_q.push_back({addr, data});
    model_sum = model_sum + data;
    model_cnt = model_cnt + 16'd1;
  endtask

  // Write monitor on dut4. Each write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [31:0] e;
      we_cyc.push_back(cyc);
      chk("we_implies_write_state", {busy, in_ready, done}, 3'b100);
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {mem_addr, mem_wdata}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers stream[0..n-1]. With toggle set, in_valid alternates every cycle.
  // The task returns just after the edge that took the last byte.
  task automatic send_bytes(input int n, input bit toggle);
    int  idx = 0;
    int  budget = 0;
    bit  v = 1'b1;
    bit  x;
    while (idx < n && budget < 200) begin
      in_data  = stream[idx];
      in_valid = toggle ? v : 1'b1;
      @(negedge clk);
      x = in_valid && in_ready;
      @(posedge clk); #1;
      if (x) idx++;
      v = ~v;
      budget++;
    end
    in_valid = 1'b0;
    chk("send_bytes_complete", idx, n);
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!done && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    start = 0; abort = 0; in_valid = 0; in_data = 0;
    d1_start = 0; d1_abort = 0; d1_valid = 0; d1_data = 0;
    model_sum = 0; model_cnt = 0;

    // Reset, then stay idle for 10 cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs4(), 72'd0);
    chk("reset_outputs_d1", outs1(), 72'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", outs4(), 72'd0);
    end

    // Full load with in_valid held high.
    stream = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
    model_sum = 0; model_cnt = 0;
    push_word(16'd0, 16'h1234);
    push_word(16'd1, 16'hABCD);
    push_word(16'd2, 16'h0001);
    push_word(16'd3, 16'hFFFF);
    we_cyc.delete();
    do_start();
    send_bytes(8, 1'b0);
    wait_done();
    chk("full_count", word_count, model_cnt);
    chk("full_checksum", checksum, model_sum);
    chk("full_checksum_const", checksum, 16'hBE01);
    chk("full_last_addr", {busy, mem_addr}, {1'b0, 16'd3});
    chk("full_write_count", we_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < we_cyc.size())
        chk("full_write_cycle", we_cyc[i], start_cyc + 3 + 3 * i);
    end

    // Start in DONE reloads from 0. in_valid toggles every cycle.
    model_sum = 0; model_cnt = 0;
    push_word(16'd0, 16'h1234);
    push_word(16'd1, 16'hABCD);
    push_word(16'd2, 16'h0001);
    push_word(16'd3, 16'hFFFF);
    do_start();
    chk("reload_clears", {done, busy, mem_addr, word_count, checksum}, {1'b0, 1'b1, 48'd0});
    send_bytes(8, 1'b1);
    wait_done();
    chk("bp_count", word_count, 16'd4);
    chk("bp_checksum", checksum, model_sum);
    chk("bp_queue_drained", exp_q.size(), 0);

    // Abort in DONE drops done and keeps the results.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done", {done, busy, word_count, checksum}, {2'b00, 16'd4, model_sum});

    // Abort in LO, after one word has been written and one byte is held.
    stream = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_word(16'd0, 16'h1234);
    do_start();
    send_bytes(3, 1'b0);
    chk("in_lo_before_abort", {busy, in_ready, mem_we}, 3'b110);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_lo_idle", {busy, done, in_ready}, 3'b000);
    chk("abort_lo_counts", {word_count, checksum}, {16'd1, 16'h1234});
    repeat (3) @(posedge clk);
    #1;
    chk("abort_lo_hold", {busy, word_count, checksum}, {1'b0, 16'd1, 16'h1234});
    do_start();
    chk("restart_clears", {mem_addr, word_count, checksum}, 48'd0);

    // Abort during the WRITE cycle of word 1.
    stream = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00};
    push_word(16'd0, 16'h1234);
    push_word(16'd1, 16'hABCD);
    send_bytes(4, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_write_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'd1, 16'hABCD});
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_write_idle", {busy, done, mem_we}, 3'b000);
    chk("abort_write_counts", {word_count, checksum}, {16'd1, 16'h1234});

    // start and abort in the same cycle in IDLE: abort wins, nothing clears.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, in_ready, word_count}, {2'b00, 16'd1});
    chk("abort_queue_drained", exp_q.size(), 0);

    // DEPTH=1: bytes 80 00 give one write at address 0, then DONE.
    @(posedge clk); #1;
    d1_start = 1'b1;
    @(posedge clk); #1;
    d1_start = 1'b0;
    d1_valid = 1'b1; d1_data = 8'h80;
    @(posedge clk); #1;
    d1_data = 8'h00;
    @(posedge clk); #1;
    d1_valid = 1'b0;
    @(negedge clk);
    chk("d1_write", {d1_we, d1_addr, d1_wdata}, {1'b1, 16'd0, 16'h8000});
    @(posedge clk); #1;
    chk("d1_done", {d1_done, d1_busy, d1_we, d1_count, d1_sum}, {3'b100, 16'd1, 16'h8000});
    @(posedge clk); #1;
    chk("d1_done_hold", {d1_done, d1_we, d1_addr}, {2'b10, 16'd0});

    // rst asserted while in LO: outputs clear before the next clock edge.
    stream = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_start();
    send_bytes(1, 1'b0);
    chk("in_lo_before_rst", {busy, in_ready}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_in_lo", outs4(), 72'd0);
    chk("rst_in_lo_d1", outs1(), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_idle", outs4(), 72'd0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
